// File: rtl/proc_param.sv
// proc_param: parametrised multicycle bus processor (R0-R7, A, G, Z on one N-bit bus).
// One instruction per Run request, stepped T0..T3 by a small control FSM.
// Optional build macro: PROC_PARAM_XOR_EN makes opcode 110 an xor; otherwise 110 is a nop.
module proc_param #(
  parameter int N = 16
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [N-1:0] DIN,
  input  logic         Run,
  output logic         Done,
  output logic [N-1:0] BusWires,
  output logic         Z
);

  // state | meaning
  // T0    | idle / fetch: latch IR when Run is high
  // T1    | first execute step (single-step ops finish here)
  // T2    | ALU ops: operand Ry onto bus, load G
  // T3    | ALU ops: G onto bus, write Rx
  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_MVNZ = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;

  step_t        step_q;
  logic [8:0]   ir_q;
  logic [N-1:0] r_q [8];
  logic [N-1:0] a_q;
  logic [N-1:0] g_q;
  logic [N-1:0] alu_d;
  logic         z_q;

  logic         ir_in, a_in, g_in, g_out, din_out, done_d, is_alu;
  logic [7:0]   r_out, r_in;
  logic [2:0]   op, rx, ry;

  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  // Which opcodes take the three-step A/G path.
  always_comb begin
    is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
`ifdef PROC_PARAM_XOR_EN
    if (op == OP_XOR) is_alu = 1'b1;
`endif
  end

  // Control decode: bus drivers and write enables for the current step.
  always_comb begin
    ir_in   = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    g_out   = 1'b0;
    din_out = 1'b0;
    done_d  = 1'b0;
    r_out   = '0;
    r_in    = '0;
    unique case (step_q)
      T0: ir_in = Run;
      T1: begin
        if (is_alu) begin
          r_out[rx] = 1'b1;
          a_in      = 1'b1;
        end else begin
          done_d = 1'b1;
          case (op)
            OP_MV: begin
              r_out[ry] = 1'b1;
              r_in[rx]  = 1'b1;
            end
            OP_MVI: begin
              din_out  = 1'b1;
              r_in[rx] = 1'b1;
            end
            OP_MVNZ: begin
              if (!z_q) begin
                r_out[ry] = 1'b1;
                r_in[rx]  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      T2: begin
        r_out[ry] = 1'b1;
        g_in      = 1'b1;
      end
      T3: begin
        g_out    = 1'b1;
        r_in[rx] = 1'b1;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Bus multiplexer; at most one source is enabled, none leaves the bus at zero.
  always_comb begin
    BusWires = '0;
    if (din_out) begin
      BusWires = DIN;
    end else if (g_out) begin
      BusWires = g_q;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (r_out[i]) BusWires = r_q[i];
      end
    end
  end

  // ALU: A combined with the bus, modulo 2^N.
  always_comb begin
    case (op)
      OP_SUB:  alu_d = a_q - BusWires;
      OP_AND:  alu_d = a_q & BusWires;
`ifdef PROC_PARAM_XOR_EN
      OP_XOR:  alu_d = a_q ^ BusWires;
`endif
      default: alu_d = a_q + BusWires;
    endcase
  end

  // Step sequencer: single-step ops return to T0 from T1, ALU ops run to T3.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step_q <= T0;
    end else begin
      unique case (step_q)
        T0: if (Run) step_q <= T1;
        T1: step_q <= done_d ? T0 : T2;
        T2: step_q <= T3;
        T3: step_q <= T0;
        default: step_q <= T0;
      endcase
    end
  end

  // Datapath registers: IR, R0-R7, A, G and the zero flag that tracks G.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ir_q <= '0;
      a_q  <= '0;
      g_q  <= '0;
      z_q  <= 1'b1;
      for (int i = 0; i < 8; i++) r_q[i] <= '0;
    end else begin
      if (ir_in) ir_q <= DIN[8:0];
      for (int i = 0; i < 8; i++) begin
        if (r_in[i]) r_q[i] <= BusWires;
      end
      if (a_in) a_q <= BusWires;
      if (g_in) begin
        g_q <= alu_d;
        z_q <= (alu_d == '0);
      end
    end
  end

  assign Done = done_d;
  assign Z    = z_q;

endmodule

// File: tb/tb_proc_param.sv
// Directed bench for proc_param (N=16). Register contents are observed by issuing
// mv Rk,Rk, which places Rk on the bus during its single execute step.
module tb_proc_param;
  localparam int N = 16;

  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_MVNZ = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;

  logic         Clock = 1'b0;
  logic         Resetn;
  logic         Run;
  logic         Done;
  logic         Z;
  logic [N-1:0] DIN;
  logic [N-1:0] BusWires;

  int n_cmp = 0;
  int n_bad = 0;

  proc_param #(.N(N)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .DIN      (DIN),
    .Run      (Run),
    .Done     (Done),
    .BusWires (BusWires),
    .Z        (Z)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Upper bits set to ones: they must be ignored for instruction words.
  function automatic logic [N-1:0] instr(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
    return {{(N-9){1'b1}}, op, x, y};
  endfunction

  // Issue one instruction from T0 (entered #1 after a rising edge), count steps to Done,
  // capture the bus in the Done step, and return #1 after the edge that ends it.
  task automatic exec(input string tag, input logic [2:0] op, input logic [2:0] x,
                      input logic [2:0] y, input logic [N-1:0] imm,
                      input int exp_steps, input logic [N-1:0] exp_bus);
    int           steps;
    bit           seen;
    logic [N-1:0] bus_done;
    steps    = 0;
    seen     = 0;
    bus_done = '0;
    DIN = instr(op, x, y);
    Run = 1'b1;
    @(posedge Clock); #1;
    Run = 1'b0;
    DIN = imm;
    while (!seen && steps < 8) begin
      steps++;
      @(negedge Clock);
      if (Done) begin
        seen     = 1;
        bus_done = BusWires;
      end
      @(posedge Clock); #1;
    end
    check_val({tag, " steps"}, steps, exp_steps);
    check_val({tag, " bus"}, bus_done, exp_bus);
  endtask

  task automatic read_reg(input string tag, input logic [2:0] k, input logic [N-1:0] exp);
    exec(tag, OP_MV, k, k, '0, 1, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn = 1'b0;
    Run    = 1'b0;
    DIN    = '0;
    #12;
    check_val("rst bus", BusWires, 0);
    check_val("rst done", Done, 0);
    check_val("rst z", Z, 1);
    @(negedge Clock); Resetn = 1'b1;
    @(posedge Clock); #1;

    // Reset in T2 of add R1,R1 aborts it.
    exec("mvi r1", OP_MVI, 3'd1, 3'd0, 16'h0003, 1, 16'h0003);
    DIN = instr(OP_ADD, 3'd1, 3'd1);
    Run = 1'b1;
    @(posedge Clock); #1;
    Run = 1'b0;
    @(posedge Clock); #1;
    check_val("pre-rst T2 bus", BusWires, 16'h0003);
    Resetn = 1'b0;
    #1;
    check_val("midrst bus", BusWires, 0);
    check_val("midrst done", Done, 0);
    check_val("midrst z", Z, 1);
    @(negedge Clock); Resetn = 1'b1;
    @(posedge Clock); #1;
    exec("mv r0,r1 after rst", OP_MV, 3'd0, 3'd1, '0, 1, 16'h0000);
    read_reg("rd r0 after rst", 3'd0, 16'h0000);

    // add with three-step latency.
    exec("mvi r0", OP_MVI, 3'd0, 3'd0, 16'h1234, 1, 16'h1234);
    exec("mvi r1", OP_MVI, 3'd1, 3'd0, 16'h0FFF, 1, 16'h0FFF);
    exec("add r0,r1", OP_ADD, 3'd0, 3'd1, '0, 3, 16'h2233);
    check_val("add z", Z, 0);
    read_reg("rd r0 sum", 3'd0, 16'h2233);
    exec("mvnz r7,r1 z0", OP_MVNZ, 3'd7, 3'd1, '0, 1, 16'h0FFF);
    read_reg("rd r7", 3'd7, 16'h0FFF);

    // sub to zero, then mvnz suppressed.
    exec("mvi r2", OP_MVI, 3'd2, 3'd0, 16'h0005, 1, 16'h0005);
    exec("mvi r3", OP_MVI, 3'd3, 3'd0, 16'h0005, 1, 16'h0005);
    exec("sub r2,r3", OP_SUB, 3'd2, 3'd3, '0, 3, 16'h0000);
    check_val("sub z", Z, 1);
    read_reg("rd r2", 3'd2, 16'h0000);
    exec("mvnz r4,r3 z1", OP_MVNZ, 3'd4, 3'd3, '0, 1, 16'h0000);
    read_reg("rd r4 mvnz", 3'd4, 16'h0000);

    // Wraparound add, then and.
    exec("mvi r5", OP_MVI, 3'd5, 3'd0, 16'hFFFF, 1, 16'hFFFF);
    exec("mvi r6", OP_MVI, 3'd6, 3'd0, 16'h0001, 1, 16'h0001);
    exec("add r5,r6 wrap", OP_ADD, 3'd5, 3'd6, '0, 3, 16'h0000);
    check_val("wrap z", Z, 1);
    exec("and r5,r6", OP_AND, 3'd5, 3'd6, '0, 3, 16'h0000);
    check_val("and z", Z, 1);
    read_reg("rd r5", 3'd5, 16'h0000);

    // Borrow wrap, X==Y doubling and self-subtract.
    exec("sub r4,r6 borrow", OP_SUB, 3'd4, 3'd6, '0, 3, 16'hFFFF);
    check_val("borrow z", Z, 0);
    read_reg("rd r4 borrow", 3'd4, 16'hFFFF);
    exec("add r6,r6", OP_ADD, 3'd6, 3'd6, '0, 3, 16'h0002);
    check_val("dbl z", Z, 0);
    exec("sub r3,r3", OP_SUB, 3'd3, 3'd3, '0, 3, 16'h0000);
    check_val("self-sub z", Z, 1);

    // Opcode 110.
    exec("mvi r1 f0", OP_MVI, 3'd1, 3'd0, 16'h00F0, 1, 16'h00F0);
    exec("mvi r2 ff0", OP_MVI, 3'd2, 3'd0, 16'h0FF0, 1, 16'h0FF0);
`ifdef PROC_PARAM_XOR_EN
    exec("xor r1,r2", OP_XOR, 3'd1, 3'd2, '0, 3, 16'h0F00);
    check_val("xor z", Z, 0);
    read_reg("rd r1 xor", 3'd1, 16'h0F00);
`else
    exec("op110 nop", OP_XOR, 3'd1, 3'd2, '0, 1, 16'h0000);
    check_val("op110 z", Z, 1);
    read_reg("rd r1 op110", 3'd1, 16'h00F0);
`endif

    // Opcode 111 nop.
    exec("nop", OP_NOP, 3'd2, 3'd1, '0, 1, 16'h0000);
    read_reg("rd r2 nop", 3'd2, 16'h0FF0);

    // Run low for five cycles: no activity.
    DIN = instr(OP_MVI, 3'd2, 3'd2);
    Run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      check_val("idle done", Done, 0);
      check_val("idle bus", BusWires, 0);
      @(posedge Clock); #1;
    end
    read_reg("rd r2 idle", 3'd2, 16'h0FF0);

    // Back-to-back with Run held high.
    DIN = instr(OP_MVI, 3'd7, 3'd7);
    Run = 1'b1;
    @(posedge Clock); #1;
    DIN = 16'h0ABC;
    @(negedge Clock);
    check_val("b2b first done", Done, 1);
    check_val("b2b first bus", BusWires, 16'h0ABC);
    @(posedge Clock); #1;
    DIN = instr(OP_MV, 3'd7, 3'd7);
    @(negedge Clock);
    check_val("b2b T0 done", Done, 0);
    @(posedge Clock); #1;
    Run = 1'b0;
    @(negedge Clock);
    check_val("b2b second done", Done, 1);
    check_val("b2b second bus", BusWires, 16'h0ABC);
    @(posedge Clock); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
